snake_move_scheduler: RTL and testbench

SNAKE_MOVE_SCHEDULER -- requirements
Module: snake_move_scheduler

---
 rtl/snake_move_scheduler.sv | 124 ++++++++++++
 tb/tb_snake_move_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/snake_move_scheduler.sv
// Snake game move scheduler: divides the clock into move ticks, latches the player's
// direction, runs the move request/ack handshake with the datapath and keeps score.
module snake_move_scheduler #(
  parameter int TICK_DIV  = 25000000,
  parameter int WIN_SCORE = 10
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [1:0] STATE_IN,
  input  logic [3:0] PUSH_BUTTONS,
  input  logic       MOVE_ACK,
  input  logic       ATE_FOOD,
  input  logic       COLLISION,
  output logic       MOVE_REQ,
  output logic [1:0] DIRECTION,
  output logic [3:0] SCORE_OUT,
  output logic       GAME_OVER
);

  localparam int                CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]        WIN       = 4'(WIN_SCORE);
  localparam logic [1:0]        DIR_RIGHT = 2'b01;

  typedef enum logic [1:0] {
    S_WAIT    = 2'b00,
    S_REQUEST = 2'b01,
    S_HALT    = 2'b10
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] prescaler, prescaler_next;
  logic [1:0]       pending, pending_next;
  logic             move_req_next;
  logic [1:0]       direction_next;
  logic [3:0]       score_next;
  logic             game_over_next;

  logic       play, idle, run, tick;
  logic       btn_valid, cand_ok;
  logic [1:0] cand;

  assign play = (STATE_IN == 2'b01);
  assign idle = (STATE_IN == 2'b00);
  assign run  = play && (state != S_HALT);
  assign tick = run && (prescaler == TICK_LAST);

  // Button index maps directly onto the direction code: up 00, right 01, down 10, left 11.
  assign btn_valid = $onehot(PUSH_BUTTONS);
  assign cand      = {PUSH_BUTTONS[2] | PUSH_BUTTONS[3], PUSH_BUTTONS[1] | PUSH_BUTTONS[3]};
  // The opposite direction differs only in the top bit of the code.
  assign cand_ok   = btn_valid && (cand != (DIRECTION ^ 2'b10));

  // State register together with every registered output.
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; reset is synchronous, so it lives inside the clocked branch.
    if (RESET) begin
      state     <= S_WAIT;
      prescaler <= '0;
      pending   <= DIR_RIGHT;
      MOVE_REQ  <= 1'b0;
      DIRECTION <= DIR_RIGHT;
      SCORE_OUT <= 4'd0;
      GAME_OVER <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      pending   <= pending_next;
      MOVE_REQ  <= move_req_next;
      DIRECTION <= direction_next;
      SCORE_OUT <= score_next;
      GAME_OVER <= game_over_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default on entry to every combinational block keeps synthesis from
    // inferring latches on paths that do not assign.
    state_next = state;
    unique case (state)
      S_WAIT:    if (!idle && tick) state_next = S_REQUEST;
      S_REQUEST: if (MOVE_ACK)      state_next = COLLISION ? S_HALT : S_WAIT;
      S_HALT:    if (idle)          state_next = S_WAIT;
      default:                      state_next = S_WAIT;
    endcase
  end

  // Next values of the registered outputs, prescaler and pending direction.
  always_comb begin
    move_req_next  = MOVE_REQ;
    direction_next = DIRECTION;
    score_next     = SCORE_OUT;
    game_over_next = GAME_OVER;
    pending_next   = cand_ok ? cand : pending;
    prescaler_next = '0;
    if (run) prescaler_next = tick ? '0 : prescaler + CNT_W'(1);

    unique case (state)
      S_WAIT, S_HALT: begin
        if (idle) begin
          score_next     = 4'd0;
          game_over_next = 1'b0;
          direction_next = DIR_RIGHT;
          pending_next   = DIR_RIGHT;
        end else if (state == S_WAIT && tick) begin
          direction_next = pending;
          move_req_next  = 1'b1;
        end
      end
      S_REQUEST: begin
        // The handshake always completes, whatever STATE_IN does meanwhile.
        if (MOVE_ACK) begin
          move_req_next = 1'b0;
          if (COLLISION)                       game_over_next = 1'b1;
          else if (ATE_FOOD && SCORE_OUT < WIN) score_next    = SCORE_OUT + 4'd1;
        end
      end
      default: move_req_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Directed bench for snake_move_scheduler with TICK_DIV=4, WIN_SCORE=10; expected
// cycle counts and values are worked out by hand from the tick timing.
module tb_snake_move_scheduler;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] STATE_IN = 2'b00;
  logic [3:0] PUSH_BUTTONS = 4'b0000;
  logic       MOVE_ACK = 1'b0;
  logic       ATE_FOOD = 1'b0;
  logic       COLLISION = 1'b0;
  logic       MOVE_REQ;
  logic [1:0] DIRECTION;
  logic [3:0] SCORE_OUT;
  logic       GAME_OVER;

  int n_checks = 0;
  int n_errors = 0;

  snake_move_scheduler #(.TICK_DIV(4), .WIN_SCORE(10)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .STATE_IN(STATE_IN), .PUSH_BUTTONS(PUSH_BUTTONS),
    .MOVE_ACK(MOVE_ACK), .ATE_FOOD(ATE_FOOD), .COLLISION(COLLISION),
    .MOVE_REQ(MOVE_REQ), .DIRECTION(DIRECTION), .SCORE_OUT(SCORE_OUT), .GAME_OVER(GAME_OVER)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Counts falling edges until MOVE_REQ is seen high (bounded at 20).
  task automatic wait_req(input string tag, input int exp_n);
    int n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while (!MOVE_REQ && n < 20);
    check(tag, n, exp_n);
  endtask

  // Called on the negedge where MOVE_REQ was first seen; ack is sampled 'delay' edges later.
  task automatic do_ack(input int delay, input logic food, input logic coll);
    repeat (delay - 1) @(negedge CLOCK);
    MOVE_ACK = 1'b1; ATE_FOOD = food; COLLISION = coll;
    @(negedge CLOCK);
    MOVE_ACK = 1'b0; ATE_FOOD = 1'b0; COLLISION = 1'b0;
  endtask

  task automatic count_reqs(input string tag, input int cycles);
    int rises = 0;
    repeat (cycles) begin
      @(negedge CLOCK);
      if (MOVE_REQ) rises++;
    end
    check(tag, rises, 0);
  endtask

  initial begin
    int held;

    // Reset state
    repeat (2) @(negedge CLOCK);
    check("rst_req", MOVE_REQ, 0);
    check("rst_dir", DIRECTION, 2'b01);
    check("rst_score", SCORE_OUT, 0);
    check("rst_go", GAME_OVER, 0);

    // First request TICK_DIV cycles after entering play, ack after 3, next 4 after first
    RESET = 1'b0; STATE_IN = 2'b01;
    wait_req("first_req_latency", 4);
    check("first_req_dir", DIRECTION, 2'b01);
    do_ack(3, 1'b0, 1'b0);
    check("req_drop_after_ack", MOVE_REQ, 0);
    wait_req("req_period_rest", 1);

    // Left rejected (opposite of right), up accepted
    do_ack(1, 1'b0, 1'b0);
    PUSH_BUTTONS = 4'b1000; @(negedge CLOCK);
    PUSH_BUTTONS = 4'b0001; @(negedge CLOCK);
    PUSH_BUTTONS = 4'b0000;
    wait_req("req_after_press", 1);
    check("dir_up", DIRECTION, 2'b00);

    // Multi-bit press and opposite (down) both ignored
    do_ack(1, 1'b0, 1'b0);
    PUSH_BUTTONS = 4'b0101; @(negedge CLOCK);
    PUSH_BUTTONS = 4'b0100; @(negedge CLOCK);
    PUSH_BUTTONS = 4'b0000;
    wait_req("req_after_bad_press", 1);
    check("dir_still_up", DIRECTION, 2'b00);

    // Last valid press wins: right then left -> left
    do_ack(1, 1'b0, 1'b0);
    PUSH_BUTTONS = 4'b0010; @(negedge CLOCK);
    PUSH_BUTTONS = 4'b1000; @(negedge CLOCK);
    PUSH_BUTTONS = 4'b0000;
    wait_req("req_after_two_press", 1);
    check("dir_left", DIRECTION, 2'b11);
    check("score_no_food", SCORE_OUT, 0);

    // Eleven food acks: score 1..10 then saturates
    for (int i = 1; i <= 11; i++) begin
      do_ack(1, 1'b1, 1'b0);
      check($sformatf("score_%0d", i), SCORE_OUT, (i > 10) ? 10 : i);
      wait_req($sformatf("food_req_%0d", i), 3);
    end

    // Collision with food: collision wins, then halted
    do_ack(1, 1'b1, 1'b1);
    check("coll_go", GAME_OVER, 1);
    check("coll_score", SCORE_OUT, 10);
    check("coll_req_low", MOVE_REQ, 0);
    count_reqs("halt_no_req", 12);
    STATE_IN = 2'b00; @(negedge CLOCK);
    check("idle_go_clr", GAME_OVER, 0);
    check("idle_score_clr", SCORE_OUT, 0);
    check("idle_dir", DIRECTION, 2'b01);

    // Leave play mid-request: MOVE_REQ held until ack, then no requests
    STATE_IN = 2'b01;
    wait_req("replay_latency", 4);
    STATE_IN = 2'b10;
    held = 1;
    repeat (4) begin
      @(negedge CLOCK);
      if (!MOVE_REQ) held = 0;
    end
    check("req_held_in_win", held, 1);
    MOVE_ACK = 1'b1; @(negedge CLOCK); MOVE_ACK = 1'b0;
    check("req_low_after_late_ack", MOVE_REQ, 0);
    count_reqs("win_no_req", 12);
    check("win_dir_kept", DIRECTION, 2'b01);

    // Stray ack in WAIT ignored, then reset during a request
    STATE_IN = 2'b01; PUSH_BUTTONS = 4'b0001; @(negedge CLOCK);
    PUSH_BUTTONS = 4'b0000;
    wait_req("resume_latency", 3);
    check("resume_dir", DIRECTION, 2'b00);
    do_ack(1, 1'b1, 1'b0);
    check("resume_score", SCORE_OUT, 1);
    MOVE_ACK = 1'b1; ATE_FOOD = 1'b1; @(negedge CLOCK);
    MOVE_ACK = 1'b0; ATE_FOOD = 1'b0;
    check("stray_ack_ignored", SCORE_OUT, 1);
    wait_req("req_before_reset", 2);
    RESET = 1'b1; @(negedge CLOCK);
    check("rst_inflight_req", MOVE_REQ, 0);
    check("rst_inflight_dir", DIRECTION, 2'b01);
    check("rst_inflight_score", SCORE_OUT, 0);
    RESET = 1'b0;
    wait_req("post_reset_latency", 4);
    check("post_reset_dir", DIRECTION, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
